// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port owner: ALU/LSU merge, LSU FIFO, busy scoreboard.
// Optional LSU_BYPASS_EN lets an LSU result skip an empty FIFO.
module reg_writeback_ctrl #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_stall,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] busy,
   output logic        WE,
   output logic [4:0]  Rw,
   output logic [31:0] busW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [31:0]   r_fifo_data [DEPTH];
   logic [4:0]    r_fifo_rd   [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [CW-1:0] r_starve;
   logic          r_stall;
   logic          r_we;
   logic [4:0]    r_rw;
   logic [31:0]   r_busw;
   logic [31:0]   r_busy;

   logic          w_empty;
   logic          w_full;
   logic          w_lsu_acc;
   logic          w_alu_win;
   logic          w_pop;
   logic          w_byp;
   logic          w_push;
   logic          w_we_nxt;
   logic [4:0]    w_rw_nxt;
   logic [31:0]   w_busw_nxt;
   logic          w_starve_hit;
   logic [31:0]   w_set;
   logic [31:0]   w_clr;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_lsu_acc = lsu_valid && !w_full;
   // ALU keeps the port even during a stall so a misbehaving upstream loses nothing
   assign w_alu_win = alu_valid && (alu_rd != 5'd0);
   assign w_pop     = !w_alu_win && !w_empty;

`ifdef LSU_BYPASS_EN
   assign w_byp = w_empty && !w_alu_win && w_lsu_acc && (lsu_rd != 5'd0);
`else
   assign w_byp = 1'b0;
`endif

   assign w_push   = w_lsu_acc && (lsu_rd != 5'd0) && !w_byp;
   assign w_we_nxt = w_alu_win || w_pop || w_byp;

   always_comb begin
      w_rw_nxt   = r_rw;
      w_busw_nxt = r_busw;
      unique case (1'b1)
         w_alu_win: begin
            w_rw_nxt   = alu_rd;
            w_busw_nxt = alu_data;
         end
         w_pop: begin
            w_rw_nxt   = r_fifo_rd[r_rptr[AW-1:0]];
            w_busw_nxt = r_fifo_data[r_rptr[AW-1:0]];
         end
         w_byp: begin
            w_rw_nxt   = lsu_rd;
            w_busw_nxt = lsu_data;
         end
         default: ;
      endcase
   end

   assign w_starve_hit = !w_empty && w_alu_win && !r_stall &&
                         (r_starve == CW'(STARVE_MAX - 1));

   assign w_set = (issue_valid && (issue_rd != 5'd0)) ?
                  (32'd1 << issue_rd) : 32'd0;
   assign w_clr = w_we_nxt ? (32'd1 << w_rw_nxt) : 32'd0;

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_fifo_data[r_wptr[AW-1:0]] <= lsu_data;
         r_fifo_rd[r_wptr[AW-1:0]]   <= lsu_rd;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_starve <= '0;
         r_stall  <= 1'b0;
         r_we     <= 1'b0;
         r_rw     <= 5'd0;
         r_busw   <= 32'd0;
         r_busy   <= 32'd0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
         if (w_pop || w_empty || r_stall)
            r_starve <= '0;
         else if (w_alu_win)
            r_starve <= r_starve + CW'(1);
         r_stall <= w_starve_hit;
         r_we    <= w_we_nxt;
         r_rw    <= w_rw_nxt;
         r_busw  <= w_busw_nxt;
         // set after clear: a same-edge reissue keeps the register busy
         r_busy  <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign alu_stall = r_stall;
   assign lsu_ready = !w_full;
   assign busy      = r_busy;
   assign WE        = r_we;
   assign Rw        = r_rw;
   assign busW      = r_busw;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: directed ALU/LSU/issue vectors.
// Honors LSU_BYPASS_EN for the expected LSU latency.
module tb_reg_writeback_ctrl;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = 5'd0;
   logic [31:0] alu_data = 32'd0;
   logic        alu_stall;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_rd = 5'd0;
   logic [31:0] lsu_data = 32'd0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = 5'd0;
   logic [31:0] busy;
   logic        WE;
   logic [4:0]  Rw;
   logic [31:0] busW;

   reg_writeback_ctrl #(.DEPTH(4), .STARVE_MAX(3)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_stall(alu_stall),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .busy(busy), .WE(WE), .Rw(Rw), .busW(busW)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        alu_q[$];
   exp_t        lsu_q[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          we_cnt = 0;
   int          we_snap;
   logic [31:0] rf [32];
   bit          t3 = 1'b0;
   int          last_stall = 0;
   int          n_stall3 = 0;
   bit          prev_stall = 1'b0;
   bit          ok;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Write monitor: ALU writes land exactly on their due cycle, LSU in order
   always @(negedge CLK) begin
      if (RSTn) begin
         if (WE) begin
            rf[Rw] = busW;
            we_cnt++;
         end
         if (alu_q.size() > 0 && alu_q[0].due == cyc) begin
            mon_e = alu_q.pop_front();
            chk("alu_we", {31'd0, WE}, 32'd1);
            chk("alu_rw", {27'd0, Rw}, {27'd0, mon_e.rd});
            chk("alu_busw", busW, mon_e.data);
         end else if (WE) begin
            if (lsu_q.size() == 0) begin
               chk("unexpected_we", {31'd0, WE}, 32'd0);
            end else begin
               mon_e = lsu_q.pop_front();
               chk("lsu_rw", {27'd0, Rw}, {27'd0, mon_e.rd});
               chk("lsu_busw", busW, mon_e.data);
               chk("lsu_min_latency", {31'd0, cyc >= mon_e.due}, 32'd1);
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (RSTn && alu_stall) begin
         chk("stall_one_cycle", {31'd0, prev_stall}, 32'd0);
         if (t3) begin
            if (last_stall != 0)
               chk("stall_period", cyc - last_stall, 32'd4);
            last_stall = cyc;
            n_stall3++;
         end
      end
      prev_stall = RSTn && alu_stall;
   end

   task automatic alu_put(input logic [4:0] rd, input logic [31:0] d);
      alu_valid = 1'b1;
      alu_rd    = rd;
      alu_data  = d;
      if (rd != 5'd0) alu_q.push_back('{rd, d, cyc + 1});
      step();
      alu_valid = 1'b0;
   endtask

   task automatic lsu_send(input logic [4:0] rd, input logic [31:0] d,
                           output bit acc);
      int a;
      acc       = 1'b0;
      lsu_valid = 1'b1;
      lsu_rd    = rd;
      lsu_data  = d;
      for (int k = 0; k < 40 && !acc; k++) begin
         if (lsu_ready) begin
            a = cyc + 1;
`ifdef LSU_BYPASS_EN
            if (rd != 5'd0) lsu_q.push_back('{rd, d, a});
`else
            if (rd != 5'd0) lsu_q.push_back('{rd, d, a + 1});
`endif
            acc = 1'b1;
         end
         step();
      end
      lsu_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 32; r++) rf[r] = 32'd0;
      #2;
      chk("rst_we", {31'd0, WE}, 32'd0);
      chk("rst_rw", {27'd0, Rw}, 32'd0);
      chk("rst_busw", busW, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
      chk("rst_stall", {31'd0, alu_stall}, 32'd0);
      repeat (2) step();
      RSTn = 1'b1;
      step();

      // ALU write, latency 1, visible in register file after negedge
      alu_put(5'd5, 32'h12345678);
      @(negedge CLK);
      #1;
      chk("rf_r5", rf[5], 32'h12345678);
      step();

      // issue then LSU result for r7
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      step();
      issue_valid = 1'b0;
      chk("busy7_set", {31'd0, busy[7]}, 32'd1);
      lsu_send(5'd7, 32'hDEADBEEF, ok);
      chk("lsu7_accept", {31'd0, ok}, 32'd1);
`ifdef LSU_BYPASS_EN
      chk("lsu7_we_lat1", {31'd0, WE}, 32'd1);
      chk("lsu7_rw_lat1", {27'd0, Rw}, 32'd7);
      chk("busy7_clr", {31'd0, busy[7]}, 32'd0);
`else
      chk("lsu7_we_lat1", {31'd0, WE}, 32'd0);
      chk("busy7_held", {31'd0, busy[7]}, 32'd1);
      step();
      chk("lsu7_we_lat2", {31'd0, WE}, 32'd1);
      chk("lsu7_rw_lat2", {27'd0, Rw}, 32'd7);
      chk("busy7_clr", {31'd0, busy[7]}, 32'd0);
`endif
      repeat (2) step();

      // ALU every cycle while LSU pushes five results
      t3         = 1'b1;
      last_stall = 0;
      n_stall3   = 0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               if (alu_stall) begin
                  alu_valid = 1'b0;
               end else begin
                  alu_valid = 1'b1;
                  alu_rd    = 5'(i + 1);
                  alu_data  = 32'hA000_0000 + 32'(i);
                  alu_q.push_back('{5'(i + 1), 32'hA000_0000 + 32'(i),
                                    cyc + 1});
               end
               step();
            end
            alu_valid = 1'b0;
         end
         begin
            for (int j = 0; j < 5; j++) begin
               bit a;
               lsu_send(5'(25 + j), 32'hB000_0000 + 32'(j), a);
               chk("t3_accept", {31'd0, a}, 32'd1);
               if (j == 3)
                  chk("t3_ready_full", {31'd0, lsu_ready}, 32'd0);
            end
         end
      join
      repeat (8) step();
      t3 = 1'b0;
      chk("t3_stall_pulses", n_stall3, 32'd5);

      // rd=0 results never write, issue_rd=0 never sets busy
      we_snap = we_cnt;
      alu_put(5'd0, 32'h55555555);
      lsu_send(5'd0, 32'h66666666, ok);
      chk("rd0_handshake", {31'd0, ok}, 32'd1);
      chk("rd0_ready", {31'd0, lsu_ready}, 32'd1);
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      step();
      issue_valid = 1'b0;
      chk("rd0_busy", busy, 32'd0);
      repeat (3) step();
      chk("rd0_no_we", we_cnt, we_snap);

      // same-edge clear and set on r9
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      step();
      issue_valid = 1'b0;
      chk("busy9_set", {31'd0, busy[9]}, 32'd1);
      issue_valid = 1'b1;
      alu_valid   = 1'b1;
      alu_rd      = 5'd9;
      alu_data    = 32'h0000_0099;
      alu_q.push_back('{5'd9, 32'h0000_0099, cyc + 1});
      step();
      issue_valid = 1'b0;
      alu_valid   = 1'b0;
      chk("same_edge_we", {31'd0, WE}, 32'd1);
      chk("same_edge_busy9", {31'd0, busy[9]}, 32'd1);
      alu_put(5'd9, 32'h0000_0999);
      chk("busy9_clr", {31'd0, busy[9]}, 32'd0);
      repeat (2) step();

      // fill FIFO with 3, mark r3 busy, reset mid-cycle
      issue_valid = 1'b1;
      issue_rd    = 5'd3;
      for (int k = 0; k < 3; k++) begin
         chk("t6_ready", {31'd0, lsu_ready}, 32'd1);
         alu_valid = 1'b1;
         alu_rd    = 5'(10 + k);
         alu_data  = 32'hC100_0000 + 32'(k);
         alu_q.push_back('{5'(10 + k), 32'hC100_0000 + 32'(k), cyc + 1});
         lsu_valid = 1'b1;
         lsu_rd    = 5'(20 + k);
         lsu_data  = 32'hC000_0000 + 32'(k);
         step();
         issue_valid = 1'b0;
      end
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      chk("t6_busy3", {31'd0, busy[3]}, 32'd1);
      #2;
      RSTn = 1'b0;
      alu_q.delete();
      lsu_q.delete();
      #1;
      chk("mid_rst_we", {31'd0, WE}, 32'd0);
      chk("mid_rst_busy", busy, 32'd0);
      chk("mid_rst_ready", {31'd0, lsu_ready}, 32'd1);
      chk("mid_rst_stall", {31'd0, alu_stall}, 32'd0);
      @(posedge CLK);
      #3;
      RSTn = 1'b1;
      we_snap = we_cnt;
      repeat (10) step();
      chk("post_rst_no_we", we_cnt, we_snap);

      chk("alu_q_drained", alu_q.size(), 32'd0);
      chk("lsu_q_drained", lsu_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
